// File: rtl/rv32i_writeback_pkg.sv
// Shared definitions for the writeback stage: load funct3 encodings, FSM states, X0.
package rv32i_writeback_pkg;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } wb_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [4:0] X0 = 5'd0;

  // Unlisted funct3 codes (011, 110, 111) fall into the word rule.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_LB, F3_LBU: is_misaligned = 1'b0;
      F3_LH, F3_LHU: is_misaligned = addr_lo[0];
      default:       is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/rv32i_writeback_load_align.sv
// Combinational load-data extraction and sign/zero extension.
module rv32i_writeback_load_align
  import rv32i_writeback_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    shifted  = data >> {addr_lo, 3'b000};
    byte_val = shifted[7:0];
    half_val = addr_lo[1] ? data[31:16] : data[15:0];
    case (funct3)
      F3_LB:   result = {{24{byte_val[7]}}, byte_val};
      F3_LBU:  result = {24'd0, byte_val};
      F3_LH:   result = {{16{half_val[15]}}, half_val};
      F3_LHU:  result = {16'd0, half_val};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/rv32i_writeback.sv
// Writeback stage feeding the split 16-entry register banks; stalls while a load is pending.
// Optional operand forwarding is built when RV32I_WB_FWD_EN is defined.
module rv32i_writeback
  import rv32i_writeback_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        res_valid_i,
  input  logic        res_is_load_i,
  input  logic [4:0]  res_rd_i,
  input  logic [31:0] res_data_i,
  input  logic [2:0]  res_funct3_i,
  input  logic [1:0]  res_addr_lo_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
`ifdef RV32I_WB_FWD_EN
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  output logic        fwd1_o,
  output logic        fwd2_o,
  output logic [31:0] fwd_data_o,
`endif
  output logic        stall_o,
  output logic [3:0]  rf_rd_o,
  output logic        rf_we_lo_o,
  output logic        rf_we_hi_o,
  output logic [31:0] rf_din_o,
  output logic        exc_misaligned_o,
  output logic        exc_timeout_o
);

  wb_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [4:0]       ld_rd_reg, ld_rd_next;
  logic [2:0]       ld_f3_reg, ld_f3_next;
  logic [1:0]       ld_addr_reg, ld_addr_next;
  logic             wr_reg, wr_next;
  logic [4:0]       wr_rd_reg, wr_rd_next;
  logic [31:0]      din_reg, din_next;
  logic             mis_reg, mis_next;
  logic             to_reg, to_next;
  logic [31:0]      load_val;
  logic             misaligned;
  logic             accept_load;

  rv32i_writeback_load_align u_align (
    .data    (mem_rdata_i),
    .funct3  (ld_f3_reg),
    .addr_lo (ld_addr_reg),
    .result  (load_val)
  );

  assign misaligned  = is_misaligned(res_funct3_i, res_addr_lo_i);
  assign accept_load = (state_reg == IDLE) && res_valid_i && res_is_load_i && !misaligned;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    ld_rd_next   = ld_rd_reg;
    ld_f3_next   = ld_f3_reg;
    ld_addr_next = ld_addr_reg;
    wr_next      = 1'b0;
    wr_rd_next   = wr_rd_reg;
    din_next     = din_reg;
    mis_next     = 1'b0;
    to_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (res_valid_i && !res_is_load_i) begin
          wr_next    = 1'b1;
          wr_rd_next = res_rd_i;
          din_next   = res_data_i;
        end else if (res_valid_i && misaligned) begin
          mis_next = 1'b1;
        end else if (accept_load) begin
          ld_rd_next   = res_rd_i;
          ld_f3_next   = res_funct3_i;
          ld_addr_next = res_addr_lo_i;
          cnt_next     = '0;
          state_next   = LOAD_WAIT;
        end
      end
      LOAD_WAIT: begin
        // A response arriving on the timeout boundary still completes the load.
        if (mem_rvalid_i) begin
          wr_next    = 1'b1;
          wr_rd_next = ld_rd_reg;
          din_next   = load_val;
          state_next = IDLE;
        end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          to_next    = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      ld_rd_reg   <= '0;
      ld_f3_reg   <= '0;
      ld_addr_reg <= '0;
      wr_reg      <= 1'b0;
      wr_rd_reg   <= '0;
      din_reg     <= '0;
      mis_reg     <= 1'b0;
      to_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      ld_rd_reg   <= ld_rd_next;
      ld_f3_reg   <= ld_f3_next;
      ld_addr_reg <= ld_addr_next;
      wr_reg      <= wr_next;
      wr_rd_reg   <= wr_rd_next;
      din_reg     <= din_next;
      mis_reg     <= mis_next;
      to_reg      <= to_next;
    end
  end

  // Stall is forced low during reset since accept_load looks at live inputs.
  assign stall_o = rst_in &&
                   (((state_reg == LOAD_WAIT) && !mem_rvalid_i) || accept_load);

  assign rf_rd_o          = wr_rd_reg[3:0];
  assign rf_we_hi_o       = wr_reg & wr_rd_reg[4];
  assign rf_we_lo_o       = wr_reg & ~wr_rd_reg[4] & (wr_rd_reg[3:0] != 4'd0);
  assign rf_din_o         = din_reg;
  assign exc_misaligned_o = mis_reg;
  assign exc_timeout_o    = to_reg;

`ifdef RV32I_WB_FWD_EN
  logic write_active;
  assign write_active = rf_we_lo_o | rf_we_hi_o;
  assign fwd1_o       = write_active && (rs1_i == wr_rd_reg) && (rs1_i != X0);
  assign fwd2_o       = write_active && (rs2_i == wr_rd_reg) && (rs2_i != X0);
  assign fwd_data_o   = din_reg;
`endif

endmodule

// File: tb/tb_rv32i_writeback.sv
// Directed self-checking bench for rv32i_writeback (TIMEOUT_CYCLES=8).
module tb_rv32i_writeback;

  logic        clk_i = 1'b0;
  logic        rst_in;
  logic        res_valid_i;
  logic        res_is_load_i;
  logic [4:0]  res_rd_i;
  logic [31:0] res_data_i;
  logic [2:0]  res_funct3_i;
  logic [1:0]  res_addr_lo_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic [3:0]  rf_rd_o;
  logic        rf_we_lo_o;
  logic        rf_we_hi_o;
  logic [31:0] rf_din_o;
  logic        exc_misaligned_o;
  logic        exc_timeout_o;
`ifdef RV32I_WB_FWD_EN
  logic [4:0]  rs1_i = 5'd0;
  logic [4:0]  rs2_i = 5'd0;
  logic        fwd1_o;
  logic        fwd2_o;
  logic [31:0] fwd_data_o;
`endif

  int checks = 0;
  int errors = 0;
  int stall_cnt;

  always #5 clk_i = ~clk_i;

  rv32i_writeback #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
    .clk_i            (clk_i),
    .rst_in           (rst_in),
    .res_valid_i      (res_valid_i),
    .res_is_load_i    (res_is_load_i),
    .res_rd_i         (res_rd_i),
    .res_data_i       (res_data_i),
    .res_funct3_i     (res_funct3_i),
    .res_addr_lo_i    (res_addr_lo_i),
    .mem_rvalid_i     (mem_rvalid_i),
    .mem_rdata_i      (mem_rdata_i),
`ifdef RV32I_WB_FWD_EN
    .rs1_i            (rs1_i),
    .rs2_i            (rs2_i),
    .fwd1_o           (fwd1_o),
    .fwd2_o           (fwd2_o),
    .fwd_data_o       (fwd_data_o),
`endif
    .stall_o          (stall_o),
    .rf_rd_o          (rf_rd_o),
    .rf_we_lo_o       (rf_we_lo_o),
    .rf_we_hi_o       (rf_we_hi_o),
    .rf_din_o         (rf_din_o),
    .exc_misaligned_o (exc_misaligned_o),
    .exc_timeout_o    (exc_timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_we(input string tag, input logic lo, input logic hi);
    chk({tag, "_we_lo"}, {31'd0, rf_we_lo_o}, {31'd0, lo});
    chk({tag, "_we_hi"}, {31'd0, rf_we_hi_o}, {31'd0, hi});
  endtask

  task automatic issue_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] a);
    res_valid_i = 1'b1; res_is_load_i = 1'b1; res_rd_i = rd;
    res_funct3_i = f3; res_addr_lo_i = a;
  endtask

  task automatic idle_inputs();
    res_valid_i = 1'b0; res_is_load_i = 1'b0; mem_rvalid_i = 1'b0;
  endtask

  initial begin
    rst_in = 1'b0;
    idle_inputs();
    res_rd_i = 5'd0; res_data_i = 32'd0; res_funct3_i = 3'd0; res_addr_lo_i = 2'd0;
    mem_rdata_i = 32'd0;

    // Reset state, including stall gated while a load request is presented
    #3;
    issue_load(5'd1, 3'b000, 2'd0);
    #1;
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_din", rf_din_o, 32'd0);
    chk("rst_rd", {28'd0, rf_rd_o}, 32'd0);
    chk_we("rst", 1'b0, 1'b0);
    chk("rst_exc", {30'd0, exc_misaligned_o, exc_timeout_o}, 32'd0);
    idle_inputs();
    tick(); tick();
    rst_in = 1'b1;
    tick();
    $display("reset released");

    // ALU write, lower bank
    res_valid_i = 1'b1; res_rd_i = 5'd5; res_data_i = 32'hDEADBEEF;
    tick();
    idle_inputs();
    chk("alu5_rd", {28'd0, rf_rd_o}, 32'd5);
    chk("alu5_din", rf_din_o, 32'hDEADBEEF);
    chk_we("alu5", 1'b1, 1'b0);
    tick();
    chk_we("alu5_pulse", 1'b0, 1'b0);
    chk("alu5_hold", rf_din_o, 32'hDEADBEEF);
    $display("alu rd=5 data=deadbeef done");

    // ALU write, upper bank
    res_valid_i = 1'b1; res_rd_i = 5'd21; res_data_i = 32'h0000A5A5;
    tick();
    idle_inputs();
    chk("alu21_rd", {28'd0, rf_rd_o}, 32'd5);
    chk_we("alu21", 1'b0, 1'b1);
    tick();
    chk_we("alu21_pulse", 1'b0, 1'b0);
    $display("alu rd=21 done");

    // x0 suppression, then x16
    res_valid_i = 1'b1; res_rd_i = 5'd0; res_data_i = 32'h00001234;
    tick();
    idle_inputs();
    chk_we("x0", 1'b0, 1'b0);
    res_valid_i = 1'b1; res_rd_i = 5'd16; res_data_i = 32'h00000016;
    tick();
    idle_inputs();
    chk("x16_rd", {28'd0, rf_rd_o}, 32'd0);
    chk_we("x16", 1'b0, 1'b1);
    chk("x16_din", rf_din_o, 32'h00000016);
    $display("x0/x16 done");

    // LB addr 3, response after 4 wait cycles
    issue_load(5'd7, 3'b000, 2'd3);
    mem_rdata_i = 32'h80FF0000;
    #1;
    stall_cnt = 0;
    chk("lb_accept_stall", {31'd0, stall_o}, 32'd1);
    stall_cnt += int'(stall_o);
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      #1;
      stall_cnt += int'(stall_o);
      chk_we("lb_wait", 1'b0, 1'b0);
      tick();
    end
    mem_rvalid_i = 1'b1;
    #1;
    chk("lb_rvalid_stall", {31'd0, stall_o}, 32'd0);
    stall_cnt += int'(stall_o);
    chk("lb_stall_cycles", stall_cnt, 32'd5);
    tick();
    mem_rvalid_i = 1'b0;
    chk("lb_din", rf_din_o, 32'hFFFFFF80);
    chk("lb_rd", {28'd0, rf_rd_o}, 32'd7);
    chk_we("lb", 1'b1, 1'b0);
    tick();
    chk_we("lb_pulse", 1'b0, 1'b0);
    $display("lb addr=3 din=%h", 32'hFFFFFF80);

    // LBU addr 3 into upper bank, response immediately
    issue_load(5'd20, 3'b100, 2'd3);
    tick();
    idle_inputs();
    mem_rvalid_i = 1'b1;
    tick();
    mem_rvalid_i = 1'b0;
    chk("lbu_din", rf_din_o, 32'h00000080);
    chk_we("lbu", 1'b0, 1'b1);
    $display("lbu addr=3 done");

    // LH addr 2 sign-extends, LHU addr 0 zero-extends, LW passes through
    issue_load(5'd9, 3'b001, 2'd2);
    tick();
    idle_inputs();
    mem_rvalid_i = 1'b1;
    tick();
    mem_rvalid_i = 1'b0;
    chk("lh_din", rf_din_o, 32'hFFFF80FF);
    issue_load(5'd9, 3'b101, 2'd0);
    mem_rdata_i = 32'h12348765;
    tick();
    idle_inputs();
    mem_rvalid_i = 1'b1;
    tick();
    mem_rvalid_i = 1'b0;
    chk("lhu_din", rf_din_o, 32'h00008765);
    issue_load(5'd9, 3'b010, 2'd0);
    tick();
    idle_inputs();
    mem_rvalid_i = 1'b1;
    tick();
    mem_rvalid_i = 1'b0;
    chk("lw_din", rf_din_o, 32'h12348765);
    $display("lh/lhu/lw done");

    // Misaligned LW addr 2
    issue_load(5'd4, 3'b010, 2'd2);
    tick();
    idle_inputs();
    chk("mis_pulse", {31'd0, exc_misaligned_o}, 32'd1);
    chk("mis_stall", {31'd0, stall_o}, 32'd0);
    chk_we("mis", 1'b0, 1'b0);
    tick();
    chk("mis_pulse_end", {31'd0, exc_misaligned_o}, 32'd0);
    $display("misaligned lw done");

    // Timeout after 8 wait cycles, then a late rvalid
    issue_load(5'd3, 3'b010, 2'd0);
    tick();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      chk("to_wait_stall", {31'd0, stall_o}, 32'd1);
      tick();
    end
    chk("to_pulse", {31'd0, exc_timeout_o}, 32'd1);
    chk("to_stall", {31'd0, stall_o}, 32'd0);
    chk_we("to", 1'b0, 1'b0);
    mem_rvalid_i = 1'b1;
    tick();
    mem_rvalid_i = 1'b0;
    chk("to_pulse_end", {31'd0, exc_timeout_o}, 32'd0);
    chk_we("to_late", 1'b0, 1'b0);
    $display("timeout done");

    // rvalid on the timeout boundary completes the load
    issue_load(5'd3, 3'b010, 2'd0);
    mem_rdata_i = 32'hCAFEF00D;
    tick();
    idle_inputs();
    for (int i = 0; i < 7; i++) tick();
    mem_rvalid_i = 1'b1;
    tick();
    mem_rvalid_i = 1'b0;
    chk("bnd_exc", {31'd0, exc_timeout_o}, 32'd0);
    chk("bnd_din", rf_din_o, 32'hCAFEF00D);
    chk_we("bnd", 1'b1, 1'b0);
    $display("boundary rvalid done");

    // Reset in LOAD_WAIT clears outputs asynchronously
    issue_load(5'd11, 3'b010, 2'd0);
    tick();
    idle_inputs();
    tick();
    chk("rl_stall_pre", {31'd0, stall_o}, 32'd1);
    #2;
    rst_in = 1'b0;
    #1;
    chk("rl_stall", {31'd0, stall_o}, 32'd0);
    chk("rl_din", rf_din_o, 32'd0);
    chk("rl_rd", {28'd0, rf_rd_o}, 32'd0);
    tick();
    rst_in = 1'b1;
    mem_rvalid_i = 1'b1;
    tick();
    mem_rvalid_i = 1'b0;
    chk_we("rl_late", 1'b0, 1'b0);
    chk("rl_late_din", rf_din_o, 32'd0);
    $display("reset mid-load done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
